avalon_arbiter_2m: RTL and testbench

Two-master to one-slave Avalon-MM arbiter placed between the masters and the unified RAM. Master 0 is the CPU memory port; master 1 is the loader/debug port used to preload programs and inspect memory while the CPU runs. It serialises accesses with fixed or round-robin priority and forwards the slave's waitrequest handshake to the granted master only.

---
 rtl/avalon_arbiter_2m.sv | 143 ++++++++++++++
 tb/tb_avalon_arbiter_2m.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_arbiter_2m.sv
// Two-master to one-slave Avalon-MM arbiter (CPU port m0, loader/debug port m1).
// Serialises accesses with round-robin or fixed priority; per-master completion counters.
module avalon_arbiter_2m #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    output logic [1:0]          grant,
    output logic [15:0]         m0_count,
    output logic [15:0]         m1_count
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t           state_reg, state_next;
    logic             last_reg, last_next;   // 1 = master 1 was served last
    logic [1:0]       req;
    logic [1:0]       done;
    logic [1:0][15:0] count_reg, count_next;

    assign req[0]  = m0_read | m0_write;
    assign req[1]  = m1_read | m1_write;
    assign done[0] = (state_reg == GNT0) && req[0] && !s_waitrequest;
    assign done[1] = (state_reg == GNT1) && req[1] && !s_waitrequest;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_count
            assign count_next[gi] = (done[gi] && (count_reg[gi] != 16'hFFFF))
                                  ? count_reg[gi] + 16'd1 : count_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (req == 2'b11)
                    state_next = (FIXED_PRIO || !last_reg) ? GNT1 : GNT0;
                else if (req[0])
                    state_next = GNT0;
                else if (req[1])
                    state_next = GNT1;
            end
            GNT0: begin
                if (!req[0]) begin
                    state_next = IDLE;
                end else if (!s_waitrequest) begin
                    last_next  = 1'b0;
                    state_next = req[1] ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                // A stalled grant is held; on completion m1 is still requesting,
                // so fixed priority keeps it.
                if (!req[1]) begin
                    state_next = IDLE;
                end else if (!s_waitrequest) begin
                    last_next = 1'b1;
                    if (FIXED_PRIO)
                        state_next = GNT1;
                    else
                        state_next = req[0] ? GNT0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        grant          = 2'b00;
        case (state_reg)
            GNT0: begin
                s_address      = m0_address;
                s_read         = m0_read;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest;
                grant          = 2'b01;
            end
            GNT1: begin
                s_address      = m1_address;
                s_read         = m1_read;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest;
                grant          = 2'b10;
            end
            default: ;
        endcase
    end

    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;
    assign m0_count    = count_reg[0];
    assign m1_count    = count_reg[1];

endmodule

// File: tb/tb_avalon_arbiter_2m.sv
// Bench for avalon_arbiter_2m: a round-robin and a fixed-priority instance share stimulus;
// a transaction-level model checks both every cycle, plus hand-computed literal checks.
module tb_avalon_arbiter_2m;

    typedef logic [169:0] vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata;
    logic        m0_read, m0_write, m1_read, m1_write, s_waitrequest;
    logic [3:0]  m0_byteenable, m1_byteenable;

    logic [31:0] s_addr_o [2];
    logic [31:0] s_wd_o   [2];
    logic [31:0] s_rd_i   [2];
    logic [31:0] m0_rd_o  [2];
    logic [31:0] m1_rd_o  [2];
    logic        s_read_o [2];
    logic        s_write_o[2];
    logic        m0_wait_o[2];
    logic        m1_wait_o[2];
    logic [3:0]  s_be_o   [2];
    logic [1:0]  grant_o  [2];
    logic [15:0] m0_cnt_o [2];
    logic [15:0] m1_cnt_o [2];

    logic [31:0] ram [16];

    int vectors     = 0;
    int miscompares = 0;

    // Model state per instance (0 = round-robin, 1 = fixed priority)
    int owner [2] = '{-1, -1};
    int last  [2] = '{1, 1};
    int cnt0  [2] = '{0, 0};
    int cnt1  [2] = '{0, 0};

    always #5 clk = ~clk;

    assign s_rd_i[0] = ram[s_addr_o[0][5:2]];
    assign s_rd_i[1] = ram[s_addr_o[1][5:2]];

    avalon_arbiter_2m #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_wait_o[0]), .m0_readdata(m0_rd_o[0]),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_wait_o[0]), .m1_readdata(m1_rd_o[0]),
        .s_address(s_addr_o[0]), .s_read(s_read_o[0]), .s_write(s_write_o[0]),
        .s_writedata(s_wd_o[0]), .s_byteenable(s_be_o[0]),
        .s_waitrequest(s_waitrequest), .s_readdata(s_rd_i[0]),
        .grant(grant_o[0]), .m0_count(m0_cnt_o[0]), .m1_count(m1_cnt_o[0])
    );

    avalon_arbiter_2m #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_wait_o[1]), .m0_readdata(m0_rd_o[1]),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_wait_o[1]), .m1_readdata(m1_rd_o[1]),
        .s_address(s_addr_o[1]), .s_read(s_read_o[1]), .s_write(s_write_o[1]),
        .s_writedata(s_wd_o[1]), .s_byteenable(s_be_o[1]),
        .s_waitrequest(s_waitrequest), .s_readdata(s_rd_i[1]),
        .grant(grant_o[1]), .m0_count(m0_cnt_o[1]), .m1_count(m1_cnt_o[1])
    );

    // Expected outputs: whoever owns the bus sees the slave; nobody owning means a quiet bus.
    function automatic vec_t model_out(int d);
        logic [1:0]  g;
        logic        sr, sw, w0, w1;
        logic [31:0] a, wd, rd;
        logic [3:0]  be;
        g = 2'b00; sr = 1'b0; sw = 1'b0; w0 = 1'b1; w1 = 1'b1;
        a = '0; wd = '0; be = '0;
        if (owner[d] == 0) begin
            g = 2'b01; sr = m0_read; sw = m0_write; a = m0_address;
            wd = m0_writedata; be = m0_byteenable; w0 = s_waitrequest;
        end else if (owner[d] == 1) begin
            g = 2'b10; sr = m1_read; sw = m1_write; a = m1_address;
            wd = m1_writedata; be = m1_byteenable; w1 = s_waitrequest;
        end
        rd = ram[a[5:2]];
        return {g, sr, sw, a, wd, be, w0, w1, rd, rd, 16'(cnt0[d]), 16'(cnt1[d])};
    endfunction

    function automatic vec_t dut_out(int d);
        return {grant_o[d], s_read_o[d], s_write_o[d], s_addr_o[d], s_wd_o[d], s_be_o[d],
                m0_wait_o[d], m1_wait_o[d], m0_rd_o[d], m1_rd_o[d], m0_cnt_o[d], m1_cnt_o[d]};
    endfunction

    // Advance the transaction model across one clock edge using the inputs held there.
    task automatic model_step(int d);
        bit r0, r1, rx, ro, fixed;
        int x;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        fixed = (d == 1);
        if (reset) begin
            owner[d] = -1; last[d] = 1; cnt0[d] = 0; cnt1[d] = 0;
        end else if (owner[d] < 0) begin
            if (r0 && r1)  owner[d] = fixed ? 1 : 1 - last[d];
            else if (r0)   owner[d] = 0;
            else if (r1)   owner[d] = 1;
        end else begin
            x  = owner[d];
            rx = (x == 1) ? r1 : r0;
            ro = (x == 1) ? r0 : r1;
            if (!rx) begin
                owner[d] = -1;
            end else if (!s_waitrequest) begin
                if (x == 0 && cnt0[d] < 65535) cnt0[d]++;
                if (x == 1 && cnt1[d] < 65535) cnt1[d]++;
                last[d] = x;
                if (fixed && r1)  owner[d] = 1;
                else if (ro)      owner[d] = 1 - x;
                else              owner[d] = -1;
            end
        end
    endtask

    initial begin
        vec_t e, a;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                e = model_out(d);
                a = dut_out(d);
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL cycle dut%0d t=%0t: got %h expected %h", d, $time, a, e);
                end
            end
            for (int d = 0; d < 2; d++) model_step(d);
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] rr_seq [4];
        rr_seq[0] = 2'b01; rr_seq[1] = 2'b10; rr_seq[2] = 2'b01; rr_seq[3] = 2'b10;
        for (int i = 0; i < 16; i++) ram[i] = 32'h1000_0000 + 32'(i);
        ram[1] = 32'h2402_0010;
        reset = 1'b1;
        m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        lit("reset_grant", 32'(grant_o[0]), 0);
        lit("reset_s_read", 32'(s_read_o[0]), 0);
        lit("reset_s_write", 32'(s_write_o[0]), 0);
        lit("reset_m0_wait", 32'(m0_wait_o[0]), 1);
        lit("reset_m1_wait", 32'(m1_wait_o[0]), 1);
        lit("reset_counts", {m0_cnt_o[0], m1_cnt_o[0]}, 0);

        // Lone m0 read of 0x04
        tick(); m0_read = 1'b1; m0_address = 32'h4;
        @(negedge clk); lit("single_before_grant", 32'(grant_o[0]), 0);
        tick();
        @(negedge clk);
        lit("single_grant", 32'(grant_o[0]), 32'h1);
        lit("single_m0_wait", 32'(m0_wait_o[0]), 0);
        lit("single_readdata", m0_rd_o[0], 32'h2402_0010);
        tick(); m0_read = 1'b0;
        @(negedge clk);
        lit("single_idle", 32'(grant_o[0]), 0);
        lit("single_m0_count", 32'(m0_cnt_o[0]), 1);

        // Both masters requesting continuously after a fresh reset
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        m0_read = 1'b1; m1_read = 1'b1; m0_address = 32'h8; m1_address = 32'hC;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            lit($sformatf("rr_grant_%0d", i), 32'(grant_o[0]), 32'(rr_seq[i]));
            lit($sformatf("fp_grant_%0d", i), 32'(grant_o[1]), 32'h2);
        end
        tick(); m0_read = 1'b0; m1_read = 1'b0;
        @(negedge clk);
        lit("rr_m0_count", 32'(m0_cnt_o[0]), 2);
        lit("rr_m1_count", 32'(m1_cnt_o[0]), 2);
        lit("fp_m0_count", 32'(m0_cnt_o[1]), 0);
        lit("fp_m1_count", 32'(m1_cnt_o[1]), 4);
        tick(); tick();

        // Fixed priority: m1 keeps the bus until it lets go
        tick(); m0_read = 1'b1; m1_read = 1'b1;
        tick(); @(negedge clk); lit("fp_hold_0", 32'(grant_o[1]), 32'h2);
        tick(); @(negedge clk); lit("fp_hold_1", 32'(grant_o[1]), 32'h2);
        tick(); m1_read = 1'b0;
        @(negedge clk); lit("fp_hold_2", 32'(grant_o[1]), 32'h2);
        tick(); @(negedge clk); lit("fp_release", 32'(grant_o[1]), 0);
        tick(); @(negedge clk); lit("fp_m0_wins", 32'(grant_o[1]), 32'h1);
        tick(); m0_read = 1'b0;
        tick();

        // Stalled m0 write while m1 waits
        tick();
        m0_write = 1'b1; m0_address = 32'h10; m0_writedata = 32'hA0; m0_byteenable = 4'hF;
        s_waitrequest = 1'b1;
        @(negedge clk); lit("stall_idle", 32'(grant_o[0]), 0);
        tick();
        m1_write = 1'b1; m1_address = 32'h20; m1_writedata = 32'h55; m1_byteenable = 4'h3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            lit($sformatf("stall_grant_%0d", i), 32'(grant_o[0]), 32'h1);
            lit($sformatf("stall_wdata_%0d", i), s_wd_o[0], 32'hA0);
            lit($sformatf("stall_m1_wait_%0d", i), 32'(m1_wait_o[0]), 1);
            lit($sformatf("stall_fp_grant_%0d", i), 32'(grant_o[1]), 32'h1);
            tick();
        end
        s_waitrequest = 1'b0;
        @(negedge clk); lit("stall_done_wait", 32'(m0_wait_o[0]), 0);
        tick(); m0_write = 1'b0; s_waitrequest = 1'b1;
        @(negedge clk);
        lit("handover_rr", 32'(grant_o[0]), 32'h2);
        lit("handover_fp", 32'(grant_o[1]), 32'h2);
        lit("handover_m1_wait", 32'(m1_wait_o[0]), 1);

        // Reset while m1 is granted and stalled
        tick(); reset = 1'b1;
        @(negedge clk); lit("pre_reset_grant", 32'(grant_o[0]), 32'h2);
        tick(); reset = 1'b0; m1_write = 1'b0; s_waitrequest = 1'b0;
        @(negedge clk);
        lit("post_reset_grant", 32'(grant_o[0]), 0);
        lit("post_reset_s_write", 32'(s_write_o[0]), 0);
        lit("post_reset_counts", {m0_cnt_o[0], m1_cnt_o[0]}, 0);

        // m0 served normally afterwards
        tick(); m0_read = 1'b1; m0_address = 32'h4;
        tick(); @(negedge clk);
        lit("after_reset_grant", 32'(grant_o[0]), 32'h1);
        lit("after_reset_rdata", m0_rd_o[0], 32'h2402_0010);
        tick(); m0_read = 1'b0;
        @(negedge clk);
        lit("after_reset_rr_count", 32'(m0_cnt_o[0]), 1);
        lit("after_reset_fp_count", 32'(m0_cnt_o[1]), 1);

        // Illegal read+write together is forwarded unchanged
        tick(); m0_read = 1'b1; m0_write = 1'b1; m0_address = 32'h14;
        tick(); @(negedge clk);
        lit("both_rw_s_read", 32'(s_read_o[0]), 1);
        lit("both_rw_s_write", 32'(s_write_o[0]), 1);
        tick(); m0_read = 1'b0; m0_write = 1'b0;
        tick(); tick();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
